// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin grant path:
//   ARB_MAX_N    largest requester count the arbiter supports
//   arb_state_e  arbiter state (IDLE: no grant held, GRANT: grant presented)
//   rr_pick      rotating-priority search returning a one-hot winner
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_MAX_N = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Returns the first set bit of req found by scanning upward from ptr and
    // wrapping at n (not at ARB_MAX_N). Callers zero-extend req to
    // ARB_MAX_N bits and keep ptr < n. Result is one-hot, or zero when no
    // bit below n is set.
    function automatic logic [ARB_MAX_N-1:0] rr_pick(
        input logic [ARB_MAX_N-1:0] req,
        input logic [3:0]           ptr,
        input logic [4:0]           n
    );
        logic [ARB_MAX_N-1:0] win;
        logic                 found;
        logic [4:0]           idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            // ptr < n and i < n, so one subtraction brings idx back into range
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (5'(i) < n) && req[idx[3:0]]) begin
                win[idx[3:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// ---------------------------------------------------------------------------
// onehot_to_bin
// Combinational N-to-IDX_W one-hot to binary encoder (N-way form of the
// 2:1 encoder). An all-zero input encodes to 0.
// Ports:
//   onehot  in   N      one-hot (or all-zero) code
//   bin     out  IDX_W  binary index of the set bit
// ---------------------------------------------------------------------------
module onehot_to_bin #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] bin
);

    // OR of the indices of all set bits; exact for a one-hot input and 0
    // for an all-zero input.
    always_comb begin
        bin = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                bin = bin | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_onehot.sv
// ---------------------------------------------------------------------------
// rr_arbiter_onehot
// Round-robin arbiter in front of the one-hot-to-binary encode stage. Turns
// N request lines into a registered, strictly one-hot grant with its binary
// index under a valid/ready handshake. Accepting a grant re-arbitrates in the
// same edge so continuous requesters are served back to back.
// Ports:
//   clk         in   1      clock, all state on posedge
//   rst         in   1      synchronous active-high reset
//   req         in   N      per-requester request, held until acked
//   ack         out  N      one-hot accept pulse (gnt_onehot when accepted)
//   gnt_valid   out  1      registered, grant outputs valid
//   gnt_ready   in   1      downstream accepts the grant this cycle
//   gnt_onehot  out  N      registered one-hot grant, zero when not valid
//   gnt_idx     out  IDX_W  registered index of gnt_onehot, zero when not valid
// ---------------------------------------------------------------------------
module rr_arbiter_onehot
    import arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     ack,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx
);

    arb_state_e       state_q,      state_d;
    logic [IDX_W-1:0] ptr_q,        ptr_d;
    logic             gnt_valid_q,  gnt_valid_d;
    logic [N-1:0]     gnt_onehot_q, gnt_onehot_d;
    logic [IDX_W-1:0] gnt_idx_q,    gnt_idx_d;

    logic             accept;
    logic [IDX_W-1:0] ptr_next;
    logic [N-1:0]     pick_req;
    logic [IDX_W-1:0] pick_ptr;
    logic [N-1:0]     win_onehot;
    logic [IDX_W-1:0] win_idx;

    // The only combinational input-to-output path is gnt_ready -> ack.
    assign accept = gnt_valid_q & gnt_ready;
    assign ack    = gnt_onehot_q & {N{accept}};

    // Pointer after the current grant retires; wraps at N, not 2^IDX_W.
    assign ptr_next = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

    // Arbitration inputs. While a grant is held, the next candidate set
    // excludes the granted requester (its req is still high in the accept
    // cycle) and the search starts just past it.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == GRANT) begin
            pick_req = req & ~gnt_onehot_q;
            pick_ptr = ptr_next;
        end
    end

    assign win_onehot = N'(rr_pick(ARB_MAX_N'(pick_req), 4'(pick_ptr), 5'(N)));

    onehot_to_bin #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .onehot (win_onehot),
        .bin    (win_idx)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_onehot_d = gnt_onehot_q;
        gnt_idx_d    = gnt_idx_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d      = GRANT;
                    gnt_valid_d  = 1'b1;
                    gnt_onehot_d = win_onehot;
                    gnt_idx_d    = win_idx;
                end
            end
            GRANT: begin
                // Without accept the grant is held as is; req changes are
                // ignored until the downstream takes it.
                if (accept) begin
                    ptr_d = ptr_next;
                    if (|pick_req) begin
                        gnt_onehot_d = win_onehot;
                        gnt_idx_d    = win_idx;
                    end else begin
                        state_d      = IDLE;
                        gnt_valid_d  = 1'b0;
                        gnt_onehot_d = '0;
                        gnt_idx_d    = '0;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = '0;
                gnt_idx_d    = '0;
            end
        endcase
    end

    // Reset overrides any handshake in the same cycle; the held grant is
    // dropped and the pointer returns to requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= '0;
            gnt_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_onehot_q <= gnt_onehot_d;
            gnt_idx_q    <= gnt_idx_d;
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_idx    = gnt_idx_q;

    // Output invariants the encode stage relies on.
    always @(posedge clk) begin
        if (!rst) begin
            a_grant_onehot: assert (gnt_valid_q ? $onehot(gnt_onehot_q)
                                                : (gnt_onehot_q == '0));
            a_idx_matches:  assert (gnt_onehot_q == (N'(gnt_valid_q) << gnt_idx_q));
            a_ack_onehot0:  assert ($onehot0(ack));
            a_state_valid:  assert ((state_q == GRANT) == gnt_valid_q);
        end
    end

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_onehot
// Directed and randomized stimulus for rr_arbiter_onehot (N=4 and N=2).
// The N=4 instance is compared every cycle against a behavioural model that
// tracks the served requester and priority start as plain integers.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_onehot;

    logic       clk;
    logic       rst4, rdy4, v4;
    logic [3:0] req4, ack4, oh4;
    logic [1:0] idx4;
    logic       rst2, rdy2, v2;
    logic [1:0] req2, ack2, oh2;
    logic [0:0] idx2;

    int ncmp  = 0;
    int nfail = 0;

    // behavioural model state for the N=4 instance
    int m_valid = 0;
    int m_idx   = 0;
    int m_ptr   = 0;

    rr_arbiter_onehot #(.N(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst4),
        .req        (req4),
        .ack        (ack4),
        .gnt_valid  (v4),
        .gnt_ready  (rdy4),
        .gnt_onehot (oh4),
        .gnt_idx    (idx4)
    );

    rr_arbiter_onehot #(.N(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst2),
        .req        (req2),
        .ack        (ack2),
        .gnt_valid  (v2),
        .gnt_ready  (rdy2),
        .gnt_onehot (oh2),
        .gnt_idx    (idx2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // first requester at or after p (mod 4) with its bit set in r
    function automatic int search(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Apply inputs mid-cycle and compare all outputs with the model.
    task automatic drive4(input logic [3:0] r, input logic rdy, input logic rs);
        logic [3:0] eoh;
        @(negedge clk);
        req4 = r;
        rdy4 = rdy;
        rst4 = rs;
        #1;
        eoh = (m_valid != 0) ? 4'(1 << m_idx) : 4'b0000;
        chk("m_valid",  32'(v4),   m_valid);
        chk("m_onehot", 32'(oh4),  32'(eoh));
        chk("m_idx",    32'(idx4), (m_valid != 0) ? m_idx : 0);
        chk("m_ack",    32'(ack4), ((m_valid != 0) && rdy) ? 32'(eoh) : 32'd0);
    endtask

    // Clock edge: advance the model from the inputs just applied.
    task automatic edge4();
        logic [3:0] rem;
        @(posedge clk);
        if (rst4) begin
            m_valid = 0;
            m_idx   = 0;
            m_ptr   = 0;
        end else if (m_valid == 0) begin
            if (req4 != 4'b0000) begin
                m_idx   = search(req4, m_ptr);
                m_valid = 1;
            end
        end else if (rdy4) begin
            m_ptr = (m_idx + 1) % 4;
            rem   = req4 & ~4'(1 << m_idx);
            if (rem != 4'b0000) begin
                m_idx = search(rem, m_ptr);
            end else begin
                m_valid = 0;
                m_idx   = 0;
            end
        end
        #1;
    endtask

    task automatic step4(input logic [3:0] r, input logic rdy, input logic rs);
        drive4(r, rdy, rs);
        edge4();
    endtask

    initial begin
        rst4 = 1'b1; req4 = 4'b1111; rdy4 = 1'b0;
        rst2 = 1'b1; req2 = 2'b11;   rdy2 = 1'b1;

        // two reset edges with every requester active
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst2_valid",  32'(v2),   32'd0);
        chk("rst2_onehot", 32'(oh2),  32'd0);
        chk("rst2_idx",    32'(idx2), 32'd0);
        chk("rst2_ack",    32'(ack2), 32'd0);
        step4(4'b1111, 1'b1, 1'b1);
        step4(4'b1111, 1'b1, 1'b1);

        // N=2 single request: grant 10 after one edge, one ack, then idle
        @(negedge clk);
        rst2 = 1'b0; req2 = 2'b10; rdy2 = 1'b0;
        @(posedge clk);
        #1;
        chk("n2_valid",  32'(v2),   32'd1);
        chk("n2_onehot", 32'(oh2),  32'h2);
        chk("n2_idx",    32'(idx2), 32'd1);
        @(negedge clk);
        rdy2 = 1'b1;
        #1;
        chk("n2_ack", 32'(ack2), 32'h2);
        @(posedge clk);
        #1;
        chk("n2_idle_valid",  32'(v2),   32'd0);
        chk("n2_idle_onehot", 32'(oh2),  32'd0);
        chk("n2_idle_ack",    32'(ack2), 32'd0);
        @(negedge clk);
        req2 = 2'b00;

        // fair rotation: all four requesting, ready every cycle
        for (int k = 0; k < 8; k++) begin
            step4(4'b1111, 1'b1, 1'b0);
            chk("rot_valid", 32'(v4),   32'd1);
            chk("rot_idx",   32'(idx4), 32'(k % 4));
        end
        step4(4'b0000, 1'b1, 1'b0);

        // backpressure: grant idx 1 held for 5 cycles while req wanders
        step4(4'b0000, 1'b0, 1'b1);
        step4(4'b0010, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step4(4'($urandom), 1'b0, 1'b0);
            chk("bp_idx",    32'(idx4), 32'd1);
            chk("bp_onehot", 32'(oh4),  32'h2);
        end
        drive4(4'b0000, 1'b1, 1'b0);
        chk("bp_ack", 32'(ack4), 32'h2);
        edge4();
        chk("bp_ack_after", 32'(ack4), 32'd0);

        // wrap and mask: ptr reaches 3, then 3 accepted with req 1001 -> 0
        step4(4'b0000, 1'b0, 1'b1);
        step4(4'b0100, 1'b0, 1'b0);
        step4(4'b1001, 1'b1, 1'b0);
        chk("wrap_idx3", 32'(idx4), 32'd3);
        step4(4'b1001, 1'b1, 1'b0);
        chk("wrap_idx0", 32'(idx4), 32'd0);
        step4(4'b0000, 1'b1, 1'b0);

        // reset mid-grant with a non-zero pointer
        step4(4'b0000, 1'b0, 1'b1);
        step4(4'b0010, 1'b0, 1'b0);
        step4(4'b0000, 1'b1, 1'b0);
        step4(4'b0100, 1'b0, 1'b0);
        chk("mid_pre_valid", 32'(v4), 32'd1);
        step4(4'b0100, 1'b0, 1'b1);
        chk("mid_rst_valid",  32'(v4),   32'd0);
        chk("mid_rst_onehot", 32'(oh4),  32'd0);
        chk("mid_rst_idx",    32'(idx4), 32'd0);
        step4(4'b0110, 1'b0, 1'b0);
        chk("mid_post_idx", 32'(idx4), 32'd1);

        // randomized traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            step4(4'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 49) == 0));
        end
        drive4(4'b0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
